gmi_arbiter: RTL

Shares one downstream GMI slave port among `NUM_M` GMI masters, such as core command engines or DMA ports, with one transaction outstanding at a time. Arbitration is round-robin and fair. The block is transparent to request and response payloads. It sits between the per-master GMI request/response channels and the single memory-side GMI target. An optional watchdog returns an error response when the target does not respond in time.

---
 rtl/gmi_arbiter_pkg.sv | 28 ++
 rtl/gmi_rr_picker.sv | 27 ++
 rtl/gmi_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/gmi_arbiter_pkg.sv
// Shared types and response codes for the GMI arbiter slice.
// Optional response watchdog is enabled with GMI_ARB_TIMEOUT_EN.
`ifndef GMI_DATA_W
`define GMI_DATA_W 32
`endif
`ifndef GMI_ADDR_W
`define GMI_ADDR_W 32
`endif
`ifndef GMI_RSP_OKAY
`define GMI_RSP_OKAY 2'b00
`endif
`ifndef GMI_RSP_TIMEOUT
`define GMI_RSP_TIMEOUT 2'b11
`endif

package gmi_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } arb_state_e;

  localparam logic [1:0] RSP_OKAY    = `GMI_RSP_OKAY;
  localparam logic [1:0] RSP_TIMEOUT = `GMI_RSP_TIMEOUT;

endpackage

// File: rtl/gmi_rr_picker.sv
// Combinational round-robin picker: first asserted request scanning up from last+1.
module gmi_rr_picker #(
  parameter int NUM_M = 4,
  parameter int IDW   = $clog2(NUM_M)
) (
  input  logic [NUM_M-1:0] req,
  input  logic [IDW-1:0]   last,
  output logic             gnt_valid,
  output logic [IDW-1:0]   gnt_idx
);

  int unsigned idx;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int unsigned k = 1; k <= NUM_M; k++) begin
      idx = (32'(last) + k) % NUM_M;
      if (!gnt_valid && req[IDW'(idx)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/gmi_arbiter.sv
// Round-robin arbiter sharing one GMI target among NUM_M masters, one transaction in flight.
// Define GMI_ARB_TIMEOUT_EN to add the response watchdog and ERR state.
`ifndef GMI_DATA_W
`define GMI_DATA_W 32
`endif
`ifndef GMI_ADDR_W
`define GMI_ADDR_W 32
`endif

module gmi_arbiter #(
  parameter int NUM_M      = 4,
  parameter int DATA_WIDTH = `GMI_DATA_W,
  parameter int ADDR_WIDTH = `GMI_ADDR_W,
  parameter int TIMEOUT    = 255,
  parameter int IDW        = $clog2(NUM_M)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_M-1:0]              m_req_valid,
  output logic [NUM_M-1:0]              m_req_ready,
  input  logic [NUM_M-1:0]              m_req_write,
  input  logic [NUM_M*ADDR_WIDTH-1:0]   m_req_addr,
  input  logic [NUM_M*DATA_WIDTH-1:0]   m_req_wdata,
  output logic [NUM_M-1:0]              m_rsp_valid,
  input  logic [NUM_M-1:0]              m_rsp_ready,
  output logic [2*NUM_M-1:0]            m_rsp_status,
  output logic [NUM_M*DATA_WIDTH-1:0]   m_rsp_rdata,
  output logic                          s_req_valid,
  output logic                          s_req_write,
  input  logic                          s_req_ready,
  output logic [ADDR_WIDTH-1:0]         s_req_addr,
  output logic [DATA_WIDTH-1:0]         s_req_wdata,
  input  logic                          s_rsp_valid,
  input  logic [1:0]                    s_rsp_status,
  input  logic [DATA_WIDTH-1:0]         s_rsp_rdata,
  output logic                          s_rsp_ready,
  output logic                          busy,
  output logic [IDW-1:0]                grant_id
);

  import gmi_arbiter_pkg::*;

  arb_state_e     state;
  logic [IDW-1:0] last;
  logic           pick_valid;
  logic [IDW-1:0] pick_idx;

  gmi_rr_picker #(
    .NUM_M (NUM_M),
    .IDW   (IDW)
  ) u_picker (
    .req       (m_req_valid),
    .last      (last),
    .gnt_valid (pick_valid),
    .gnt_idx   (pick_idx)
  );

`ifdef GMI_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  logic [CW-1:0] tmo_cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      last        <= IDW'(NUM_M - 1);
      grant_id    <= '0;
      busy        <= 1'b0;
      s_req_valid <= 1'b0;
      s_req_write <= 1'b0;
      s_req_addr  <= '0;
      s_req_wdata <= '0;
`ifdef GMI_ARB_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          // The picker's winner always has valid set, so a pick is a handshake.
          if (pick_valid) begin
            s_req_valid <= 1'b1;
            s_req_write <= m_req_write[pick_idx];
            s_req_addr  <= m_req_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
            s_req_wdata <= m_req_wdata[pick_idx*DATA_WIDTH +: DATA_WIDTH];
            grant_id    <= pick_idx;
            last        <= pick_idx;
            busy        <= 1'b1;
            state       <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (s_req_ready) begin
            s_req_valid <= 1'b0;
            state       <= ST_RESP;
`ifdef GMI_ARB_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
          end
        end
        ST_RESP: begin
          if (s_rsp_valid && m_rsp_ready[grant_id]) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
`ifdef GMI_ARB_TIMEOUT_EN
          else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
            state <= ST_ERR;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
`ifdef GMI_ARB_TIMEOUT_EN
        ST_ERR: begin
          if (m_rsp_ready[grant_id]) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    m_req_ready  = '0;
    m_rsp_valid  = '0;
    m_rsp_status = '0;
    m_rsp_rdata  = '0;
    s_rsp_ready  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_valid) m_req_ready[pick_idx] = 1'b1;
`ifdef GMI_ARB_TIMEOUT_EN
        s_rsp_ready = 1'b1;
`endif
      end
      ST_REQ: begin
`ifdef GMI_ARB_TIMEOUT_EN
        s_rsp_ready = 1'b1;
`endif
      end
      ST_RESP: begin
        m_rsp_valid[grant_id]                           = s_rsp_valid;
        m_rsp_status[2*grant_id +: 2]                   = s_rsp_status;
        m_rsp_rdata[grant_id*DATA_WIDTH +: DATA_WIDTH]  = s_rsp_rdata;
        s_rsp_ready                                     = m_rsp_ready[grant_id];
      end
`ifdef GMI_ARB_TIMEOUT_EN
      ST_ERR: begin
        // Late target responses are accepted and dropped while the error is pending.
        m_rsp_valid[grant_id]         = 1'b1;
        m_rsp_status[2*grant_id +: 2] = RSP_TIMEOUT;
        s_rsp_ready                   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule
